// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: serialises one frame onto an I2S-style bit clock / data pair.
// A 16-bit header {num_modules_x, num_modules_y, 2'b00, row_num} goes out first,
// followed by PAYLOAD_WORDS 32-bit words pulled through a valid/ready handshake.
// Every bit is sent MSB first and takes two clk cycles: sck low with the new
// bit, then sck high with the bit held.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid / req_ready        frame request handshake (ready only in IDLE)
//   num_modules_x/_y, row_num    header fields, captured on accept
//   word_data/_valid/_ready      payload word handshake (ready pulses in LOAD)
//   i2s_sck, i2s_data            serial bit clock (clk/2, gated) and data
//   busy, done                   frame in progress, one-cycle end-of-frame pulse
module i2s_frame_tx #(
  parameter int unsigned PAYLOAD_WORDS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  num_modules_x,
  input  logic [3:0]  num_modules_y,
  input  logic [5:0]  row_num,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        i2s_sck,
  output logic        i2s_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HDR_BITS  = 16;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_PAYLOAD,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   phase_q, phase_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic                   sck_q, sck_d;
  logic                   data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      sck_q      <= 1'b0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      sck_q      <= sck_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register
  // in the same cycle as the state they describe.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    sck_d      = 1'b0;
    data_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_HEADER;
          shift_d    = {num_modules_x, num_modules_y, 2'b00, row_num, 16'h0000};
          phase_d    = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      S_HEADER: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          // No shift after the last bit so LOAD keeps driving it
          if (bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
            state_d = S_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = {shift_q[WORD_BITS-2:0], 1'b0};
          end
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          state_d    = S_PAYLOAD;
          shift_d    = word_data;
          phase_d    = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end
      end
      S_PAYLOAD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
            state_d = (word_cnt_q >= CNT_W'(PAYLOAD_WORDS)) ? S_DONE : S_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = {shift_q[WORD_BITS-2:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        phase_d    = 1'b0;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        shift_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    // sck only toggles while bits are moving; LOAD stalls it low
    sck_d  = phase_d && ((state_d == S_HEADER) || (state_d == S_PAYLOAD));
    data_d = ((state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_PAYLOAD))
             ? shift_d[WORD_BITS-1] : 1'b0;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign word_ready = (state_q == S_LOAD) && word_valid;
  assign i2s_sck    = sck_q;
  assign i2s_data   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: a receiver model samples i2s_data on sck rising edges
// and checks each assembled header / word against a queue of expected items.
module tb_i2s_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv1, rv3;
  logic [3:0]  nx, ny;
  logic [5:0]  row;
  logic [31:0] word_data;
  logic        word_valid;
  logic        rr1, wr1, sck1, dat1, busy1, done1;
  logic        rr3, wr3, sck3, dat3, busy3, done3;
  logic        sel;

  always #5 clk = ~clk;

  i2s_frame_tx #(.PAYLOAD_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1),
    .num_modules_x(nx), .num_modules_y(ny), .row_num(row),
    .word_data(word_data), .word_valid(word_valid), .word_ready(wr1),
    .i2s_sck(sck1), .i2s_data(dat1), .busy(busy1), .done(done1)
  );

  i2s_frame_tx #(.PAYLOAD_WORDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3),
    .num_modules_x(nx), .num_modules_y(ny), .row_num(row),
    .word_data(word_data), .word_valid(word_valid), .word_ready(wr3),
    .i2s_sck(sck3), .i2s_data(dat3), .busy(busy3), .done(done3)
  );

  logic m_rr, m_wr, m_sck, m_dat, m_busy, m_done;
  assign m_rr   = sel ? rr3   : rr1;
  assign m_wr   = sel ? wr3   : wr1;
  assign m_sck  = sel ? sck3  : sck1;
  assign m_dat  = sel ? dat3  : dat1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;

  typedef struct {
    int unsigned len;
    logic [31:0] val;
  } item_t;

  item_t       exp_q[$];
  int unsigned edge_q[$];
  logic [31:0] wq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned flush_req = 0;
  int unsigned takes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Receiver: assemble bits on sck rising edges, compare against expected items
  task automatic monitor();
    logic        prev = 1'b0;
    logic [31:0] acc = '0;
    int unsigned nbits = 0;
    int unsigned edges = 0;
    int unsigned seen = 0;
    item_t       it;
    forever begin
      @(negedge clk);
      if (seen != flush_req) begin
        seen = flush_req;
        exp_q.delete();
        edge_q.delete();
        acc = '0; nbits = 0; edges = 0; prev = 1'b0;
      end
      if (m_sck && !prev) begin
        edges++;
        if (exp_q.size() == 0) begin
          check("unexpected_sck_edge", 32'd1, 32'd0);
        end else begin
          acc = {acc[30:0], m_dat};
          nbits++;
          if (nbits == exp_q[0].len) begin
            it = exp_q.pop_front();
            check("serial_word", acc, it.val);
            acc = '0;
            nbits = 0;
          end
        end
      end
      prev = m_sck;
      if (m_done) begin
        if (edge_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("sck_edge_count", 32'(edges), 32'(edge_q.pop_front()));
        edges = 0;
      end
    end
  endtask

  // Word source: presents wq[0], pops it after the edge that consumed it
  task automatic feeder();
    logic take;
    forever begin
      @(negedge clk);
      take = word_valid && (wr1 || wr3);
      @(posedge clk);
      #1;
      if (take && wq.size() > 0) begin
        void'(wq.pop_front());
        takes++;
      end
      word_valid = (wq.size() > 0);
      word_data  = word_valid ? wq[0] : 32'h0;
    end
  endtask

  // Runs one frame on the selected DUT; called and returns at a negedge
  task automatic do_frame(input logic [3:0] x, input logic [3:0] y, input logic [5:0] r,
                          input logic [15:0] exp_hdr,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int unsigned nw, input int unsigned stall,
                          input bit toggle, input int unsigned exp_lat);
    logic [31:0] ws[3];
    int unsigned k;
    int unsigned bad = 0;
    int unsigned t0;
    bit          got = 1'b0;
    item_t       it;
    ws = '{w0, w1, w2};
    check("req_ready_idle", 32'(m_rr), 32'd1);
    it.len = 16; it.val = 32'(exp_hdr);
    exp_q.push_back(it);
    for (int i = 0; i < int'(nw); i++) begin
      it.len = 32; it.val = ws[i];
      exp_q.push_back(it);
    end
    edge_q.push_back(16 + 32 * nw);
    if (stall == 0) for (int i = 0; i < int'(nw); i++) wq.push_back(ws[i]);
    t0 = takes;
    nx = x; ny = y; row = r;
    if (sel) rv3 = 1'b1; else rv1 = 1'b1;
    @(posedge clk);
    #1;
    rv1 = 1'b0; rv3 = 1'b0;
    check("busy_after_accept", 32'(m_busy), 32'd1);
    for (k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (toggle) begin
        if (k < 60) begin
          rv1 = k[0];
          nx  = 4'($urandom);
          ny  = 4'($urandom);
          row = 6'($urandom);
        end else begin
          rv1 = 1'b0;
        end
      end
      @(negedge clk);
      if (stall > 0 && k == 31 + stall)
        for (int i = 0; i < int'(nw); i++) wq.push_back(ws[i]);
      if (stall > 0 && k >= 32 && k < 32 + stall)
        if (m_sck !== 1'b0 || m_dat !== exp_hdr[0] || m_wr !== 1'b0) bad++;
      if (m_done) begin
        got = 1'b1;
        break;
      end
    end
    if (stall > 0) check("stall_holds_bus", 32'(bad), 32'd0);
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_latency", 32'(k), 32'(exp_lat));
      check("busy_in_done", 32'(m_busy), 32'd1);
      check("req_ready_in_done", 32'(m_rr), 32'd0);
    end
    check("word_ready_pulses", 32'(takes - t0), 32'(nw));
    @(negedge clk);
    check("idle_after_done", 32'({m_busy, m_done, m_sck, m_dat, m_rr}), 32'b00001);
  endtask

  initial begin
    item_t it;
    rst_n = 1'b0; rv1 = 1'b0; rv3 = 1'b0; sel = 1'b0;
    nx = '0; ny = '0; row = '0; word_data = '0; word_valid = 1'b0;
    fork
      monitor();
      feeder();
    join_none

    repeat (2) @(negedge clk);
    check("reset_outputs_dut1", 32'({rr1, busy1, done1, sck1, dat1, wr1}), 32'b100000);
    check("reset_outputs_dut3", 32'({rr3, busy3, done3, sck3, dat3, wr3}), 32'b100000);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, then a back-to-back frame with row 1
    do_frame(4'd1, 4'd0, 6'd0, 16'h1000, 32'hA5A5_0F0F, 32'h0, 32'h0, 1, 0, 1'b0, 97);
    do_frame(4'd1, 4'd0, 6'd1, 16'h1001, 32'h1234_5678, 32'h0, 32'h0, 1, 0, 1'b0, 97);
    @(negedge clk);

    // Word underflow: 10 stalled LOAD cycles, header ends in a 1
    do_frame(4'd3, 4'd5, 6'h2B, 16'h352B, 32'h0123_4567, 32'h0, 32'h0, 1, 10, 1'b0, 107);
    @(negedge clk);

    // Request and header inputs wiggle while busy
    do_frame(4'hF, 4'hE, 6'h3F, 16'hFE3F, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 0, 1'b1, 97);
    repeat (4) @(negedge clk);
    check("no_second_frame", 32'({busy1, rr1}), 32'b01);

    // Reset asserted at payload bit 20, phase 0
    it.len = 16; it.val = 32'h9611;
    exp_q.push_back(it);
    it.len = 32; it.val = 32'hCAFE_F00D;
    exp_q.push_back(it);
    wq.push_back(32'hCAFE_F00D);
    nx = 4'd9; ny = 4'd6; row = 6'h11;
    rv1 = 1'b1;
    @(posedge clk);
    #1;
    rv1 = 1'b0;
    repeat (73) @(posedge clk);
    @(negedge clk);
    check("sck_low_before_reset", 32'(sck1), 32'd0);
    rst_n = 1'b0;
    flush_req++;
    #1;
    check("async_reset_outputs", 32'({rr1, busy1, done1, sck1, dat1, wr1}), 32'b100000);
    repeat (3) @(negedge clk);
    check("reset_held_quiet", 32'({busy1, sck1, dat1}), 32'b000);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(4'd2, 4'd4, 6'd5, 16'h2405, 32'h8000_0001, 32'h0, 32'h0, 1, 0, 1'b0, 97);
    @(negedge clk);

    // Three-word payload on the second instance
    sel = 1'b1;
    @(negedge clk);
    do_frame(4'd2, 4'd3, 6'd7, 16'h2307, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
             3, 0, 1'b0, 227);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size() + edge_q.size() + wq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_frame_tx.md
I2S_FRAME_TX -- requirements
Module: i2s_frame_tx

Interface
REQ-001 SHALL have parameter: PAYLOAD_WORDS, default 1, number of 32-bit payload words sent after each header (legal range 1..16).
REQ-002 SHALL have ports: clk  input  1  system clock; all logic is rising-edge clk.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: req_valid  input  1  frame request.
REQ-005 SHALL have ports: req_ready  output  1  block is idle and can accept a request.
REQ-006 SHALL have ports: num_modules_x  input  4  header field; num_modules_y  input  4  header field; row_num  input  6  header field.
REQ-007 SHALL have ports: word_data  input  32  payload word; word_valid  input  1  payload word available; word_ready  output  1  payload word consumed this cycle.
REQ-008 SHALL have ports: i2s_sck  output  1  serial bit clock, clk/2, low when gated; i2s_data  output  1  serial data, MSB first.
REQ-009 SHALL have ports: busy  output  1  frame in progress; done  output  1  one-cycle end-of-frame pulse.

Function
REQ-010 SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.
REQ-011 SHALL form the header as {num_modules_x, num_modules_y, 2'b00, row_num}, 16 bits.
REQ-012 SHALL capture all three header fields on the rising edge where req_valid && req_ready.
REQ-013 SHALL transmit the header and then each payload word MSB first.
REQ-014 SHALL implement states IDLE, HEADER, LOAD, PAYLOAD, DONE.
REQ-015 SHALL drive req_ready = 1 only in IDLE (combinational from state).
REQ-016 IDLE -> HEADER on accept; HEADER -> LOAD after 16 bits; LOAD -> PAYLOAD on the cycle word_valid = 1.
REQ-017 PAYLOAD -> LOAD after 32 bits if more words remain; otherwise PAYLOAD -> DONE; DONE -> IDLE after 1 cycle.
REQ-018 SHALL give each bit 2 clk cycles in HEADER/PAYLOAD: phase 0 drives i2s_sck = 0 with i2s_data set to the new bit, phase 1 drives i2s_sck = 1 with i2s_data held, so the receiver samples on the sck rising edge.
REQ-019 SHALL drive word_ready = word_valid while in LOAD (one-cycle pulse), loading word_data into a 32-bit shift register on that edge.
REQ-020 SHALL hold i2s_sck = 0 and hold i2s_data at the last bit for every cycle spent in LOAD (word underflow stalls the bus clock, with no spurious edges).
REQ-021 SHALL count payload words in a 5-bit counter, compared against PAYLOAD_WORDS.
REQ-022 SHALL count bits within the header (0..15) and within a word (0..31) with no wrap beyond the terminal count.
REQ-023 SHALL drive busy = 1 in HEADER, LOAD, PAYLOAD and DONE.
REQ-024 SHALL drive done = 1 only in DONE, and i2s_sck = 0, i2s_data = 0 in DONE and IDLE.
REQ-025 SHALL ignore req_valid while busy; header inputs may change freely after capture without affecting the frame in flight.
REQ-026 SHALL, with word_valid already high, produce a frame of accept cycle T, HEADER T+1..T+32, LOAD T+33, PAYLOAD T+34..T+97, DONE T+98, and req_ready = 1 at T+99 (PAYLOAD_WORDS = 1).
REQ-027 SHALL permit a new accept in the first IDLE cycle after DONE (back-to-back frames, one IDLE cycle minimum between them).

Reset
REQ-028 SHALL, while rst_n = 0, immediately force state IDLE, i2s_sck = 0, i2s_data = 0, busy = 0, done = 0, word_ready = 0, req_ready = 1, and clear all counters and the shift register.
REQ-029 SHALL abandon a frame when reset asserts mid-frame, with no further sck edges; after release the block is in IDLE and the next frame starts from header bit 15.

Verification
REQ-030 Scenario: x = 1, y = 0, row = 0, word 0xA5A5_0F0F valid -> 48 sck rising edges; sampled bits = 0x1000 then 0xA5A50F0F; done pulses at T+98.
REQ-031 Scenario: back-to-back frames with row 0 then row 1 -> second header sampled = 0x1001; exactly one IDLE cycle between done and the second accept.
REQ-032 Scenario: word_valid held low 10 cycles at LOAD -> i2s_sck stays 0 for those cycles, no extra edges, payload bits correct after word_valid rises.
REQ-033 Scenario: PAYLOAD_WORDS = 3 -> three word_ready pulses, 16 + 96 = 112 sck rising edges, one done.
REQ-034 Scenario: rst_n pulsed low during payload bit 20 -> outputs go to reset values asynchronously; a subsequent request sends a complete, correct frame.
REQ-035 Scenario: req_valid toggled and header inputs changed while busy -> no effect on the serialized header; no second frame starts.
